// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Accepts one word-addressed request at a time, waits LATENCY cycles, then
// commits stores (byte-enabled) or returns the full 32-bit word for loads.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    request handshake (ready decoded from state)
//   req_we, req_be     store flag and byte enables (be ignored for loads)
//   req_addr           byte address, word index is addr[31:2]
//   req_wdata          lane-aligned store data
//   rsp_valid          single-cycle completion pulse
//   rsp_rdata, rsp_err read word and error flag, valid with rsp_valid
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, err_q;
  logic [3:0]      be_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     wdata_q;

  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic            accept, capture;
  logic            req_err;
  logic [IdxW-1:0] req_idx;

  // Access port: either the captured request (end of WAIT) or, with
  // LATENCY==1, the request being accepted this very edge.
  logic            do_access, acc_we, acc_err;
  logic [3:0]      acc_be;
  logic [IdxW-1:0] acc_idx;
  logic [31:0]     acc_wdata;

  logic unused_addr;
  assign unused_addr = ^req_addr[1:0];

  assign req_ready = (state_q == StIdle) || (state_q == StResp);
  assign accept    = req_valid && req_ready;
  assign req_idx   = req_addr[IdxW+1:2];
  assign req_err   = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) ||
                     (req_we && (req_be == 4'b0000));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    do_access   = 1'b0;
    acc_we      = we_q;
    acc_err     = err_q;
    acc_be      = be_q;
    acc_idx     = idx_q;
    acc_wdata   = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          capture = 1'b1;
          cnt_d   = CntInit;
          if (LATENCY == 1) begin
            state_d   = StResp;
            do_access = 1'b1;
            acc_we    = req_we;
            acc_err   = req_err;
            acc_be    = req_be;
            acc_idx   = req_idx;
            acc_wdata = req_wdata;
          end else begin
            state_d = StWait;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) begin
          state_d   = StResp;
          cnt_d     = 4'd0;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_access) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err || acc_we) ? 32'h0 : mem[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      be_q        <= 4'b0;
      idx_q       <= '0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (capture) begin
        we_q    <= req_we;
        err_q   <= req_err;
        be_q    <= req_be;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
      end
    end
  end

  // Array is not reset; rst_n gates writes so an accept during reset with
  // LATENCY==1 cannot commit.
  always_ff @(posedge clk) begin
    if (rst_n && do_access && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned Depth = 64;

  logic        clk;
  logic        rst_n;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        vld   [3];
  logic        rdy   [3];
  logic        rv    [3];
  logic [31:0] rdata [3];
  logic        err   [3];

  logic [31:0] model [3][Depth];

  int vectors;
  int miscompares;

  // Instance 0: LATENCY=1, 1: LATENCY=2, 2: LATENCY=3.
  dmem_responder #(.DEPTH_WORDS(Depth), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[0]),
    .rsp_rdata(rdata[0]), .rsp_err(err[0])
  );
  dmem_responder #(.DEPTH_WORDS(Depth), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[1]),
    .rsp_rdata(rdata[1]), .rsp_err(err[1])
  );
  dmem_responder #(.DEPTH_WORDS(Depth), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[2]),
    .rsp_rdata(rdata[2]), .rsp_err(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int s);
    return s + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated transaction on instance s; checks latency, ready, err and rdata
  // against the word-array model, and returns the observed read data.
  task automatic txn(input int s, input logic we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    int k;
    int lat;
    logic [31:0] exp_d;
    logic exp_e;
    lat = lat_of(s);
    @(posedge clk); #1;
    req_we = we; req_be = be; req_addr = addr; req_wdata = wd; vld[s] = 1'b1;
    @(negedge clk);
    k = 0;
    while (!rdy[s] && k < 20) begin @(negedge clk); k++; end
    chk("accept_ready", 32'(rdy[s]), 32'd1);
    exp_e = (addr[31:2] >= 30'(Depth)) || (we && be == 4'b0000);
    exp_d = (exp_e || we) ? 32'h0 : model[s][addr[7:2]];
    if (!exp_e && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model[s][addr[7:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end
    @(posedge clk); #1;
    vld[s] = 1'b0;
    for (k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) chk("no_early_rsp", 32'(rv[s]), 32'd0);
      if (k == 1 && lat > 1) chk("busy_not_ready", 32'(rdy[s]), 32'd0);
    end
    chk("rsp_valid", 32'(rv[s]), 32'd1);
    chk("rsp_err", 32'(err[s]), 32'(exp_e));
    chk("rsp_rdata", rdata[s], exp_d);
    rd = rdata[s];
  endtask

  initial begin
    logic [31:0] rd;
    int acc;
    int rsp;
    int acc_at [2];
    int rsp_at [2];
    int pulses;
    logic [31:0] ra;
    logic rwe;
    logic [3:0] rbe;

    vectors = 0;
    miscompares = 0;
    for (int s = 0; s < 3; s++) vld[s] = 1'b0;
    req_we = 1'b0; req_be = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("reset_ready", 32'(rdy[s]), 32'd1);
      chk("reset_valid", 32'(rv[s]), 32'd0);
      chk("reset_rdata", rdata[s], 32'h0);
      chk("reset_err", 32'(err[s]), 32'd0);
    end
    #22;
    rst_n = 1'b1;

    // LATENCY=2 directed sequence.
    txn(1, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, rd);
    txn(1, 1'b0, 4'b0000, 32'h10, 32'h0, rd);
    chk("plan_load_deadbeef", rd, 32'hDEADBEEF);
    txn(1, 1'b1, 4'b0100, 32'h12, 32'h00AB0000, rd);
    txn(1, 1'b0, 4'b1111, 32'h10, 32'h0, rd);
    chk("plan_partial", rd, 32'hDEABBEEF);
    txn(1, 1'b1, 4'b1111, 32'(4 * Depth), 32'h55555555, rd);
    chk("plan_oob_err", 32'(err[1]), 32'd1);
    txn(1, 1'b1, 4'b0000, 32'h10, 32'h77777777, rd);
    chk("plan_be0_err", 32'(err[1]), 32'd1);
    txn(1, 1'b0, 4'b0000, 32'h10, 32'h0, rd);
    chk("plan_after_err", rd, 32'hDEABBEEF);

    // Reset during WAIT discards the pending store.
    txn(1, 1'b1, 4'b1111, 32'h30, 32'h11223344, rd);
    @(posedge clk); #1;
    req_we = 1'b1; req_be = 4'b1111; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
    vld[1] = 1'b1;
    @(negedge clk);
    chk("rst_accept_ready", 32'(rdy[1]), 32'd1);
    @(posedge clk); #1;
    vld[1] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(rdy[1]), 32'd1);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rv[1]) pulses++;
    end
    chk("rst_no_rsp", 32'(pulses), 32'd0);
    txn(1, 1'b0, 4'b0000, 32'h30, 32'h0, rd);
    chk("rst_array_kept", rd, 32'h11223344);

    // LATENCY=1 back-to-back store then load.
    @(posedge clk); #1;
    req_we = 1'b1; req_be = 4'b1111; req_addr = 32'h20; req_wdata = 32'h12345678;
    vld[0] = 1'b1;
    @(negedge clk);
    chk("b2b_ready0", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    req_we = 1'b0; req_be = 4'b0000; req_wdata = 32'h0;
    @(negedge clk);
    chk("b2b_store_rsp", 32'(rv[0]), 32'd1);
    chk("b2b_store_err", 32'(err[0]), 32'd0);
    chk("b2b_ready1", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(negedge clk);
    chk("b2b_load_rsp", 32'(rv[0]), 32'd1);
    chk("b2b_load_data", rdata[0], 32'h12345678);
    chk("b2b_ready2", 32'(rdy[0]), 32'd1);
    model[0][8] = 32'h12345678;

    // LATENCY=3 with req_valid held while busy.
    txn(2, 1'b1, 4'b1111, 32'h08, 32'hA5A5F00D, rd);
    txn(2, 1'b1, 4'b1111, 32'h0C, 32'h0BADCAFE, rd);
    @(posedge clk); #1;
    req_we = 1'b0; req_be = 4'b0000; req_addr = 32'h08; vld[2] = 1'b1;
    acc = 0; rsp = 0;
    acc_at[0] = -1; acc_at[1] = -1; rsp_at[0] = -1; rsp_at[1] = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rv[2]) begin
        if (rsp < 2) rsp_at[rsp] = i;
        if (rsp == 0) chk("held_rdata_a", rdata[2], 32'hA5A5F00D);
        if (rsp == 1) chk("held_rdata_b", rdata[2], 32'h0BADCAFE);
        rsp++;
      end
      if (rdy[2] && vld[2]) begin
        if (acc < 2) acc_at[acc] = i;
        acc++;
      end
      @(posedge clk); #1;
      if (acc == 1) req_addr = 32'h0C;
      if (acc == 2) vld[2] = 1'b0;
    end
    chk("held_accepts", 32'(acc), 32'd2);
    chk("held_pulses", 32'(rsp), 32'd2);
    chk("held_acc_b_at", 32'(acc_at[1]), 32'd3);
    chk("held_rsp_a_at", 32'(rsp_at[0]), 32'd3);
    chk("held_rsp_b_at", 32'(rsp_at[1]), 32'd6);

    // Randomized traffic against the model; words 0..7 initialised first.
    for (int s = 0; s < 3; s++) begin
      for (int w = 0; w < 8; w++) begin
        txn(s, 1'b1, 4'b1111, 32'(4 * w), $urandom, rd);
      end
    end
    for (int n = 0; n < 60; n++) begin
      rwe = 1'($urandom_range(0, 1));
      rbe = 4'($urandom_range(0, 15));
      ra  = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) ra = ra | 32'(4 * Depth);
      txn(n % 3, rwe, rbe, ra, $urandom, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
